// File: rtl/neander_mem_arbiter.sv
// Shares the NEANDER-X RAM between the CPU port (default owner) and a loader port.
// Optional starvation steal (one-cycle CPU stall) is enabled by defining NEANDER_ARB_STEAL_EN.
module neander_mem_arbiter #(
    parameter int unsigned MAX_WAIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_re,
    input  logic       cpu_we,
    output logic [7:0] cpu_rdata,
    output logic       cpu_stall,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [7:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_ack,
    output logic [7:0] dbg_rdata,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    output logic       ram_re,
    output logic       ram_we,
    input  logic [7:0] ram_rdata,
    output logic [1:0] arb_state
);

    // Handshake: dbg_req is a level held (with dbg_we/addr/wdata stable) until the
    // single-cycle dbg_ack pulse; dbg_req is ignored during the ack cycle.

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
`ifdef NEANDER_ARB_STEAL_EN
        S_ACK   = 2'd2,
        S_STEAL = 2'd3
`else
        S_ACK   = 2'd2
`endif
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       dbg_ack_q, dbg_ack_d;
    logic [7:0] dbg_rdata_q, dbg_rdata_d;
    logic       grant;
    logic       cpu_busy;

    assign cpu_busy = cpu_re | cpu_we;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        grant      = 1'b0;
        cpu_stall  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (dbg_req) begin
                    if (!cpu_busy) begin
                        grant   = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        state_d    = S_WAIT;
                        wait_cnt_d = 8'd1;
                    end
                end
            end
            S_WAIT: begin
                if (!dbg_req) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = 8'd0;
                end else if (!cpu_busy) begin
                    grant      = 1'b1;
                    state_d    = S_ACK;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q < MAX_WAIT_C) begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end else begin
`ifdef NEANDER_ARB_STEAL_EN
                    state_d = S_STEAL;
`else
                    state_d = S_WAIT;
`endif
                end
            end
`ifdef NEANDER_ARB_STEAL_EN
            S_STEAL: begin
                grant      = 1'b1;
                cpu_stall  = 1'b1;
                state_d    = S_ACK;
                wait_cnt_d = 8'd0;
            end
`endif
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = 8'd0;
            end
        endcase
        // Never hand the RAM to the loader while reset is asserted.
        if (!reset) begin
            grant     = 1'b0;
            cpu_stall = 1'b0;
        end
        dbg_ack_d   = grant;
        dbg_rdata_d = (grant && !dbg_we) ? ram_rdata : dbg_rdata_q;
    end

    always_comb begin
        if (grant) begin
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
            ram_re    = ~dbg_we;
            ram_we    = dbg_we;
        end else begin
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
            ram_re    = cpu_re;
            ram_we    = cpu_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= 8'd0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign cpu_rdata = ram_rdata;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;
    assign arb_state = state_q;

endmodule
